detect_event_monitor: RTL

Downstream consumer of the sequence-detector output (`out_bit`, high while the detector sits in its final state). It detects rising edges of that level, counts detection events, measures how many consecutive cycles the detector stays in the detect state and records the longest such run. It drives a two-digit, time-multiplexed hex view of the event count onto the single 7-segment display.

---
 rtl/detect_event_monitor_if.sv | 25 ++
 rtl/detect_event_monitor.sv | 117 +++++++++++
 2 files changed

// File: rtl/detect_event_monitor_if.sv
// Bundles the detector-level inputs and the statistics/display outputs of detect_event_monitor.
// master: drives det_in/clear/hold; slave: the monitor itself.
interface detect_event_monitor_if #(
    parameter int NBITS_EVT = 8,
    parameter int NBITS_RUN = 8
);
    logic                 det_in;
    logic                 clear;
    logic                 hold;
    logic                 event_pulse;
    logic [NBITS_EVT-1:0] event_count;
    logic [NBITS_RUN-1:0] run_len;
    logic [NBITS_RUN-1:0] max_run;
    logic [7:0]           SEG;

    modport master (
        output det_in, clear, hold,
        input  event_pulse, event_count, run_len, max_run, SEG
    );

    modport slave (
        input  det_in, clear, hold,
        output event_pulse, event_count, run_len, max_run, SEG
    );
endinterface

// File: rtl/detect_event_monitor.sv
// Counts rising edges of the detector level, tracks current/longest high run, shows the count as two muxed hex digits (EVT_SATURATE_EN: count saturates at FF).
// Latency: statistics and event_pulse 1 cycle after the sampling edge; SEG combinational from registered display state.
// Backpressure: none, every cycle is consumed.
module detect_event_monitor #(
    parameter int NBITS_EVT   = 8,
    parameter int NBITS_RUN   = 8,
    parameter int DISP_PERIOD = 4
) (
    input  logic                   clk_2,
    input  logic                   reset,
    detect_event_monitor_if.slave  bus
);
    localparam int              DIV_W    = (DISP_PERIOD > 1) ? $clog2(DISP_PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DISP_PERIOD - 1);

    logic                 r_det_prev;
    logic                 r_event_pulse;
    logic                 r_digit_sel;
    logic [NBITS_EVT-1:0] r_event_count;
    logic [NBITS_EVT-1:0] r_disp_val;
    logic [NBITS_RUN-1:0] r_run_len;
    logic [NBITS_RUN-1:0] r_max_run;
    logic [DIV_W-1:0]     r_div_cnt;

    logic                 w_rise;
    logic [NBITS_EVT-1:0] w_count_nxt;
    logic [NBITS_EVT-1:0] w_disp_nxt;
    logic [NBITS_RUN-1:0] w_run_nxt;
    logic [NBITS_RUN-1:0] w_max_nxt;
    logic [3:0]           w_nibble;
    logic [6:0]           w_glyph;

    always_comb begin
        w_rise      = bus.det_in & ~r_det_prev;
        w_count_nxt = r_event_count;
        w_run_nxt   = '0;
        w_max_nxt   = r_max_run;
        w_disp_nxt  = r_disp_val;
        if (bus.clear) begin
            w_count_nxt = '0;
            w_max_nxt   = '0;
            w_disp_nxt  = '0;
        end else begin
            if (w_rise) begin
`ifdef EVT_SATURATE_EN
                if (r_event_count != '1)
                    w_count_nxt = r_event_count + NBITS_EVT'(1);
`else
                w_count_nxt = r_event_count + NBITS_EVT'(1);
`endif
            end
            if (w_rise)
                w_run_nxt = NBITS_RUN'(1);
            else if (bus.det_in)
                w_run_nxt = (r_run_len == '1) ? r_run_len : r_run_len + NBITS_RUN'(1);
            if (w_run_nxt > r_max_run)
                w_max_nxt = w_run_nxt;
            if (!bus.hold)
                w_disp_nxt = w_count_nxt;
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_det_prev    <= 1'b0;
            r_event_pulse <= 1'b0;
            r_event_count <= '0;
            r_run_len     <= '0;
            r_max_run     <= '0;
            r_disp_val    <= '0;
            r_div_cnt     <= '0;
            r_digit_sel   <= 1'b0;
        end else begin
            // det_prev keeps sampling through clear so a level held across it is not recounted
            r_det_prev    <= bus.det_in;
            r_event_pulse <= w_rise & ~bus.clear;
            r_event_count <= w_count_nxt;
            r_run_len     <= w_run_nxt;
            r_max_run     <= w_max_nxt;
            r_disp_val    <= w_disp_nxt;
            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt   <= '0;
                r_digit_sel <= ~r_digit_sel;
            end else begin
                r_div_cnt   <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    always_comb begin
        w_nibble = r_digit_sel ? r_disp_val[7:4] : r_disp_val[3:0];
        case (w_nibble)
            4'h0:    w_glyph = 7'h3F;
            4'h1:    w_glyph = 7'h06;
            4'h2:    w_glyph = 7'h5B;
            4'h3:    w_glyph = 7'h4F;
            4'h4:    w_glyph = 7'h66;
            4'h5:    w_glyph = 7'h6D;
            4'h6:    w_glyph = 7'h7D;
            4'h7:    w_glyph = 7'h07;
            4'h8:    w_glyph = 7'h7F;
            4'h9:    w_glyph = 7'h6F;
            4'hA:    w_glyph = 7'h77;
            4'hB:    w_glyph = 7'h7C;
            4'hC:    w_glyph = 7'h39;
            4'hD:    w_glyph = 7'h5E;
            4'hE:    w_glyph = 7'h79;
            default: w_glyph = 7'h71;
        endcase
    end

    assign bus.event_pulse = r_event_pulse;
    assign bus.event_count = r_event_count;
    assign bus.run_len     = r_run_len;
    assign bus.max_run     = r_max_run;
    assign bus.SEG         = {r_digit_sel, w_glyph};
endmodule
